// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with hex decode, leading-zero
// suppression, an inter-digit guard interval and a frame-synchronous double buffer.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val;
  logic [NUM_DIGITS-1:0] pend_dp, pend_blank, act_dp, act_blank;
  logic pend_valid;

  logic term, wrap, transfer, dark;
  logic [3:0] cur_nib;
  logic cur_dp, cur_blank, lz_dark, all_zero;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction

  assign term     = (cnt == CNT_MAX);
  assign wrap     = en && term && (idx == IDX_MAX);
  assign transfer = pend_valid && (wrap || !en);

  // Walk from the most significant digit down so all_zero tracks "this digit and everything above it is 0".
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    lz_dark   = 1'b0;
    all_zero  = 1'b1;
    onehot    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (act_val[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        cur_nib   = act_val[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = act_blank[k];
        lz_dark   = lz_blank && (k > 0) && all_zero;
        onehot[k] = 1'b1;
      end
    end
    dark = !en || cur_blank || lz_dark || (cnt < GUARD_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (term) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A load coinciding with a transfer lands in pending and keeps pending_valid set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (transfer) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_val   <= value_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end else if (transfer) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= SEG_OFF;
      dp       <= SEG_ACTIVE_LOW;
      digit_en <= DIG_OFF;
    end else begin
      seg      <= (dark ? 7'h00 : decode(cur_nib)) ^ SEG_OFF;
      dp       <= (!dark && cur_dp) ^ SEG_ACTIVE_LOW;
      digit_en <= (dark ? '0 : onehot) ^ DIG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a position-based frame model pushes expected pin states each clock;
// a monitor pops them and compares both an active-high and an inverted-polarity DUT.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int GD = 2;

  logic clk = 1'b0;
  logic rst_n, en, load, lz_blank;
  logic [15:0] value_in;
  logic [3:0] dp_in, blank_in;

  logic [6:0] seg, seg_i;
  logic dp, dp_i, frame_done, frame_done_i;
  logic [3:0] digit_en, digit_en_i;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [12:0] exp_q[$];
  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(GD),
                     .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .digit_en(digit_en), .frame_done(frame_done));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(GD),
                     .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_blank(lz_blank),
    .seg(seg_i), .dp(dp_i), .digit_en(digit_en_i), .frame_done(frame_done_i));

  task automatic checkOutput(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got seg=%h dp=%b dig=%b fd=%b, expected seg=%h dp=%b dig=%b fd=%b",
               name, $time, got[12:6], got[5], got[4:1], got[0], exp[12:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Reference model: the scan position is a plain cycle count since en rose; slot and phase come from division.
  initial begin
    int p, slot, phase;
    bit dark, wrapf, pv;
    logic [15:0] act, pend;
    logic [3:0] act_dp, act_bl, pend_dp, pend_bl, nib;
    logic [12:0] e;
    p = 0; pv = 0; act = '0; pend = '0;
    act_dp = '0; act_bl = '0; pend_dp = '0; pend_bl = '0;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        p = 0; pv = 0; act = '0; pend = '0;
        act_dp = '0; act_bl = '0; pend_dp = '0; pend_bl = '0;
      end else begin
        if (!en) begin
          if (pv) begin act = pend; act_dp = pend_dp; act_bl = pend_bl; pv = 0; end
          p = 0;
        end else begin
          slot  = (p / RD) % N;
          phase = p % RD;
          nib   = 4'((act >> (4 * slot)) & 16'hF);
          dark  = act_bl[slot] || (lz_blank && slot > 0 && (act >> (4 * slot)) == 16'h0) || phase < GD;
          wrapf = (phase == RD - 1) && (slot == N - 1);
          if (!dark) begin
            e[12:6] = seg_tab[nib];
            e[5]    = act_dp[slot];
            e[4:1]  = 4'(1 << slot);
          end
          e[0] = wrapf;
          if (wrapf && pv) begin act = pend; act_dp = pend_dp; act_bl = pend_bl; pv = 0; end
          p = (p + 1) % (RD * N);
        end
        if (load) begin pend = value_in; pend_dp = dp_in; pend_bl = blank_in; pv = 1; end
      end
      exp_q.push_back(e);
    end
  end

  initial begin
    logic [12:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL scoreboard underflow at %0t: got empty queue, expected one entry", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pins", {seg, dp, digit_en, frame_done}, e);
        checkOutput("pins_inv", {seg_i, dp_i, digit_en_i, frame_done_i}, e ^ 13'h1FFE);
      end
    end
  end

  task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] b, input bit e, input bit lz);
    @(negedge clk);
    load = ld; value_in = v; dp_in = d; blank_in = b; en = e; lz_blank = lz;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic waitFrame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL frame_done timeout: got no pulse in %0d cycles, expected one within %0d", n, N * RD);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
    value_in = '0; dp_in = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic decode of 0x1234");
    applyStimulus(1'b1, 16'h1234, 4'b0000, 4'b0000, 1'b1, 1'b0);
    idle(3 * N * RD);

    $display("[TB] leading-zero suppression");
    applyStimulus(1'b1, 16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    idle(2 * N * RD);
    applyStimulus(1'b0, 16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    idle(N * RD);

    $display("[TB] load on the wrap cycle");
    waitFrame();
    idle(N * RD - 2);
    applyStimulus(1'b1, 16'hFFFF, 4'b0000, 4'b0000, 1'b1, 1'b0);
    idle(3 * N * RD);

    $display("[TB] dp and blanking, code walk");
    applyStimulus(1'b1, 16'hC3A5, 4'b0100, 4'b0001, 1'b1, 1'b0);
    idle(2 * N * RD);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, {4'(4*c+3), 4'(4*c+2), 4'(4*c+1), 4'(4*c)}, 4'(c), 4'b0000, 1'b1, 1'b0);
      idle(2 * N * RD);
    end

    $display("[TB] enable toggle mid-slot");
    idle(13);
    applyStimulus(1'b0, 16'h8421, 4'b0000, 4'b0000, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 16'h5A5A, 4'b1010, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h5A5A, 4'b1010, 4'b0000, 1'b1, 1'b0);
    idle(2 * N * RD);

    $display("[TB] randomized traffic");
    repeat (60) begin
      applyStimulus(($urandom_range(0, 2) != 0), 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                    ($urandom_range(0, 9) != 0), 1'($urandom));
      idle($urandom_range(0, 24));
    end

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, 16'h0F0F, 4'b1111, 4'b0000, 1'b1, 1'b0);
    idle(N * RD + 11);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {seg, dp, digit_en, frame_done}, 13'h0000);
    checkOutput("async_reset_inv", {seg_i, dp_i, digit_en_i, frame_done_i}, 13'h1FFE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h9876, 4'b0001, 4'b0000, 1'b1, 1'b1);
    idle(3 * N * RD);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
